// File: rtl/ela_field_feeder_if.sv
// ela_field_feeder_if: upstream pixel stream plus ELA request/burst and status signals
interface ela_field_feeder_if #(parameter int DW = 8);
  logic [DW-1:0] s_data, in_data;
  logic s_valid, s_sof, s_ready, req, field_done, err_underrun, err_sync;
  logic [4:0] line_cnt;
  modport master(output s_data, s_valid, s_sof, req,
                 input s_ready, in_data, line_cnt, field_done, err_underrun, err_sync);
  modport slave(input s_data, s_valid, s_sof, req,
                output s_ready, in_data, line_cnt, field_done, err_underrun, err_sync);
endinterface

// File: rtl/ela_field_feeder.sv
// ela_field_feeder: two-bank ping-pong line buffer serving WIDTH-cycle line bursts to ELA on req
module ela_field_feeder #(
  parameter int DW = 8,
  parameter int WIDTH = 32,
  parameter int LINES = 16
) (
  input logic clk,
  input logic rst,
  ela_field_feeder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_n;
  logic [DW-1:0] mem [2][WIDTH];
  logic [1:0] bank_full;
  logic wr_bank, rd_bank;
  logic [CW-1:0] wr_col, rd_col, col;
  logic acc, fill, start, rel, last_line;
  assign bus.s_ready = !bank_full[wr_bank];
  assign acc = bus.s_valid & bus.s_ready;
  // a start-of-field pixel always lands in column 0, dropping any partial line
  assign col = bus.s_sof ? '0 : wr_col;
  assign fill = acc && col == CW'(WIDTH - 1);
  assign start = state == IDLE && bus.req && bank_full[rd_bank];
  assign rel = state == BURST && rd_col == CW'(WIDTH - 1);
  assign last_line = bus.line_cnt == 5'(LINES - 1);
  always_comb begin
    state_n = start ? BURST : rel ? IDLE : state;
    bus.in_data = state == BURST ? mem[rd_bank][rd_col] : bank_full[rd_bank] ? mem[rd_bank][0] : '0;
  end
  always_ff @(posedge clk)
    if (acc) mem[wr_bank][col] <= bus.s_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      bank_full <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_col <= '0;
      rd_col <= '0;
      bus.line_cnt <= '0;
      bus.field_done <= 1'b0;
      bus.err_underrun <= 1'b0;
      bus.err_sync <= 1'b0;
    end else begin
      state <= state_n;
      bank_full <= (bank_full & ~({1'b0, rel} << rd_bank)) | ({1'b0, fill} << wr_bank);
      wr_col <= acc ? (fill ? '0 : col + 1'b1) : wr_col;
      wr_bank <= wr_bank ^ fill;
      rd_col <= start ? CW'(1) : state == BURST ? rd_col + 1'b1 : rd_col;
      rd_bank <= rd_bank ^ rel;
      bus.line_cnt <= rel ? (last_line ? '0 : bus.line_cnt + 5'd1) : bus.line_cnt;
      bus.field_done <= rel && last_line;
      bus.err_underrun <= bus.err_underrun | (state == IDLE && bus.req && !bank_full[rd_bank]);
      bus.err_sync <= bus.err_sync | (acc && bus.s_sof && wr_col != '0);
    end
endmodule
